// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the in-order issue controller: decode group bit
// positions, default limits and the issue-unit enumeration.
package issue_ctrl_pkg;

    localparam int RFIDX_W_DEF    = 5;
    localparam int MAX_OUTST_DEF  = 4;
    localparam int CNT_W_DEF      = 3;

    localparam int DECINFO_GRPLEN = 6;
    localparam int GRP_ALU        = 0;
    localparam int GRP_LSU        = 1;
    localparam int GRP_BJU        = 2;
    localparam int GRP_MDU        = 3;
    localparam int GRP_SCU        = 4;
    localparam int GRP_ADD        = 5;

    typedef enum logic [2:0] {
        UNIT_ALU = 3'd0,
        UNIT_LSU = 3'd1,
        UNIT_BJU = 3'd2,
        UNIT_MDU = 3'd3,
        UNIT_SCU = 3'd4,
        UNIT_NOP = 3'd5
    } issue_unit_e;

    // Fixed priority alu > lsu > bju > mdu > scu; the add hint never selects a unit.
    function automatic issue_unit_e sel_unit(input logic [DECINFO_GRPLEN-1:0] grp);
        issue_unit_e u;
        if (grp[GRP_ALU]) begin
            u = UNIT_ALU;
        end else if (grp[GRP_LSU]) begin
            u = UNIT_LSU;
        end else if (grp[GRP_BJU]) begin
            u = UNIT_BJU;
        end else if (grp[GRP_MDU]) begin
            u = UNIT_MDU;
        end else if (grp[GRP_SCU]) begin
            u = UNIT_SCU;
        end else begin
            u = UNIT_NOP;
        end
        return u;
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode/function-unit/writeback signal bundle of the issue controller.
interface issue_ctrl_if
    import issue_ctrl_pkg::*;
#(
    parameter int RFIDX_W = RFIDX_W_DEF
);
    logic                      i_dec_vld;
    logic                      o_dec_rdy;
    logic                      i_rdwen;
    logic [RFIDX_W-1:0]        i_rdidx;
    logic                      i_rs1ren;
    logic [RFIDX_W-1:0]        i_rs1idx;
    logic                      i_rs2ren;
    logic [RFIDX_W-1:0]        i_rs2idx;
    logic [DECINFO_GRPLEN-1:0] i_decinfo_grp;
    logic                      i_lsu_wr;
    logic                      o_alu_vld, o_lsu_vld, o_bju_vld, o_mdu_vld, o_scu_vld;
    logic                      i_alu_rdy, i_lsu_rdy, i_bju_rdy, i_mdu_rdy, i_scu_rdy;
    logic                      i_lwb_vld;
    logic [RFIDX_W-1:0]        i_lwb_rdidx;
    logic                      i_nwb_done;
    logic                      i_flush;
    logic                      o_idle;
    logic                      o_err;

    modport master (
        output i_dec_vld, i_rdwen, i_rdidx, i_rs1ren, i_rs1idx, i_rs2ren, i_rs2idx,
               i_decinfo_grp, i_lsu_wr, i_alu_rdy, i_lsu_rdy, i_bju_rdy, i_mdu_rdy,
               i_scu_rdy, i_lwb_vld, i_lwb_rdidx, i_nwb_done, i_flush,
        input  o_dec_rdy, o_alu_vld, o_lsu_vld, o_bju_vld, o_mdu_vld, o_scu_vld,
               o_idle, o_err
    );

    modport slave (
        input  i_dec_vld, i_rdwen, i_rdidx, i_rs1ren, i_rs1idx, i_rs2ren, i_rs2idx,
               i_decinfo_grp, i_lsu_wr, i_alu_rdy, i_lsu_rdy, i_bju_rdy, i_mdu_rdy,
               i_scu_rdy, i_lwb_vld, i_lwb_rdidx, i_nwb_done, i_flush,
        output o_dec_rdy, o_alu_vld, o_lsu_vld, o_bju_vld, o_mdu_vld, o_scu_vld,
               o_idle, o_err
    );
endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// Per-register busy vector for long-latency results, with writeback bypass on
// every lookup so a result arriving this cycle never stalls its consumer.
module issue_scoreboard #(
    parameter int RFIDX_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_set,
    input  logic [RFIDX_W-1:0] i_set_idx,
    input  logic               i_clr,
    input  logic [RFIDX_W-1:0] i_clr_idx,
    input  logic [RFIDX_W-1:0] i_rs1_idx,
    input  logic [RFIDX_W-1:0] i_rs2_idx,
    input  logic [RFIDX_W-1:0] i_rd_idx,
    output logic               o_rs1_busy,
    output logic               o_rs2_busy,
    output logic               o_rd_busy,
    output logic               o_clr_hit
);
    localparam int NREG = 1 << RFIDX_W;

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    function automatic logic busy(input logic [NREG-1:0] sb, input logic clr,
                                  input logic [RFIDX_W-1:0] clr_idx,
                                  input logic [RFIDX_W-1:0] idx);
        return sb[idx] & ~(clr & (clr_idx == idx));
    endfunction

    assign o_rs1_busy = busy(sb_q, i_clr, i_clr_idx, i_rs1_idx);
    assign o_rs2_busy = busy(sb_q, i_clr, i_clr_idx, i_rs2_idx);
    assign o_rd_busy  = busy(sb_q, i_clr, i_clr_idx, i_rd_idx);
    assign o_clr_hit  = sb_q[i_clr_idx];

    // Next busy vector: clear first, then set so a same-index reissue stays busy.
    always_comb begin
        sb_d = sb_q;
        if (i_clr) begin
            sb_d[i_clr_idx] = 1'b0;
        end else begin
            sb_d = sb_d;
        end
        if (i_set) begin
            sb_d[i_set_idx] = 1'b1;
        end else begin
            sb_d = sb_d;
        end
        sb_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end
endmodule

// File: rtl/issue_ctrl.sv
// In-order single-issue dispatch: hazard and capacity gating in front of the
// function units, outstanding long-op counter and sticky protocol error.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int RFIDX_W   = RFIDX_W_DEF,
    parameter int MAX_OUTST = MAX_OUTST_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    issue_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    issue_unit_e      unit_s;
    logic             sel_alu_s, sel_lsu_s, sel_bju_s, sel_mdu_s, sel_scu_s, sel_nop_s;
    logic             long_s, ser_s;
    logic             rs1_busy_s, rs2_busy_s, rd_busy_s, clr_hit_s;
    logic             haz_s, cap_ok_s, go_s, nop_acc_s, issue_long_s, sb_set_s;
    logic [CNT_W:0]   sum_s, dec_s;
    logic             under_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign unit_s    = sel_unit(bus.i_decinfo_grp);
    assign sel_alu_s = (unit_s == UNIT_ALU);
    assign sel_lsu_s = (unit_s == UNIT_LSU);
    assign sel_bju_s = (unit_s == UNIT_BJU);
    assign sel_mdu_s = (unit_s == UNIT_MDU);
    assign sel_scu_s = (unit_s == UNIT_SCU);
    assign sel_nop_s = (unit_s == UNIT_NOP);
    assign long_s    = sel_lsu_s | sel_mdu_s;
    assign ser_s     = sel_scu_s | sel_nop_s;

    issue_scoreboard #(.RFIDX_W(RFIDX_W)) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set      (sb_set_s),
        .i_set_idx  (bus.i_rdidx),
        .i_clr      (bus.i_lwb_vld),
        .i_clr_idx  (bus.i_lwb_rdidx),
        .i_rs1_idx  (bus.i_rs1idx),
        .i_rs2_idx  (bus.i_rs2idx),
        .i_rd_idx   (bus.i_rdidx),
        .o_rs1_busy (rs1_busy_s),
        .o_rs2_busy (rs2_busy_s),
        .o_rd_busy  (rd_busy_s),
        .o_clr_hit  (clr_hit_s)
    );

    assign haz_s = (bus.i_rs1ren & rs1_busy_s) | (bus.i_rs2ren & rs2_busy_s)
                 | (bus.i_rdwen & rd_busy_s);

    // Serialising ops wait for a drained pipeline with nothing completing this cycle.
    always_comb begin
        if (long_s) begin
            cap_ok_s = (cnt_q < MAX_C);
        end else if (ser_s) begin
            cap_ok_s = (cnt_q == '0) & ~bus.i_lwb_vld & ~bus.i_nwb_done;
        end else begin
            cap_ok_s = 1'b1;
        end
    end

    assign go_s      = bus.i_dec_vld & ~haz_s & cap_ok_s & ~bus.i_flush & ~i_rst;
    assign nop_acc_s = bus.i_dec_vld & sel_nop_s & cap_ok_s & ~bus.i_flush & ~i_rst;

    assign bus.o_alu_vld = go_s & sel_alu_s;
    assign bus.o_lsu_vld = go_s & sel_lsu_s;
    assign bus.o_bju_vld = go_s & sel_bju_s;
    assign bus.o_mdu_vld = go_s & sel_mdu_s;
    assign bus.o_scu_vld = go_s & sel_scu_s;
    assign bus.o_dec_rdy = (bus.o_alu_vld & bus.i_alu_rdy) | (bus.o_lsu_vld & bus.i_lsu_rdy)
                         | (bus.o_bju_vld & bus.i_bju_rdy) | (bus.o_mdu_vld & bus.i_mdu_rdy)
                         | (bus.o_scu_vld & bus.i_scu_rdy) | nop_acc_s;

    assign issue_long_s = bus.o_dec_rdy & long_s;
    assign sb_set_s     = bus.o_dec_rdy & bus.i_rdwen
                        & (sel_mdu_s | (sel_lsu_s & ~bus.i_lsu_wr));

    assign sum_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, issue_long_s};
    assign dec_s = {{CNT_W{1'b0}}, bus.i_lwb_vld} + {{CNT_W{1'b0}}, bus.i_nwb_done};

    // Counter next state saturates at zero; a writeback to a non-busy register is an error.
    always_comb begin
        if (sum_s < dec_s) begin
            cnt_d   = '0;
            under_s = 1'b1;
        end else begin
            cnt_d   = CNT_W'(sum_s - dec_s);
            under_s = 1'b0;
        end
        err_d = err_q | under_s
              | (bus.i_lwb_vld & (~clr_hit_s | (bus.i_lwb_rdidx == '0)));
    end

    // Outstanding counter and sticky error registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.o_idle = (cnt_q == '0);
    assign bus.o_err  = err_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural issue model.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    issue_ctrl_if #(.RFIDX_W(5)) bus();

    issue_ctrl #(.RFIDX_W(5), .MAX_OUTST(4), .CNT_W(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    bit m_sb[32];
    int m_cnt = 0;
    bit m_err = 1'b0;
    bit m_ok  = 1'b0;
    bit e_acc = 1'b0, e_long = 1'b0, e_set = 1'b0;

    function automatic bit m_busy(input int x);
        return (x != 0) && m_sb[x] && !(bus.i_lwb_vld && int'(bus.i_lwb_rdidx) == x);
    endfunction

    // Compare process: expectations from the current inputs and model state, then advance the model.
    always @(negedge clk) begin
        int u, li;
        bit haz, cap, go, acc, lng, ser;
        bit [4:0] rdy;
        u = 5;
        for (int k = 4; k >= 0; k--) if (bus.i_decinfo_grp[k]) u = k;
        rdy = {bus.i_scu_rdy, bus.i_mdu_rdy, bus.i_bju_rdy, bus.i_lsu_rdy, bus.i_alu_rdy};
        haz = (bus.i_rs1ren && m_busy(int'(bus.i_rs1idx))) || (bus.i_rs2ren && m_busy(int'(bus.i_rs2idx)))
           || (bus.i_rdwen && m_busy(int'(bus.i_rdidx)));
        lng = (u == 1) || (u == 3);
        ser = (u == 4) || (u == 5);
        cap = lng ? (m_cnt < 4) : (ser ? (m_cnt == 0 && !bus.i_lwb_vld && !bus.i_nwb_done) : 1'b1);
        go  = bus.i_dec_vld && !haz && cap && !bus.i_flush && !rst;
        acc = (u == 5) ? (bus.i_dec_vld && cap && !bus.i_flush && !rst) : (go && rdy[u]);
        if (m_ok) begin
            chk("alu_vld", bus.o_alu_vld, go && u == 0);
            chk("lsu_vld", bus.o_lsu_vld, go && u == 1);
            chk("bju_vld", bus.o_bju_vld, go && u == 2);
            chk("mdu_vld", bus.o_mdu_vld, go && u == 3);
            chk("scu_vld", bus.o_scu_vld, go && u == 4);
            chk("dec_rdy", bus.o_dec_rdy, acc);
            chk("idle", bus.o_idle, m_cnt == 0);
            chk("err", bus.o_err, m_err);
        end
        e_acc  = acc;
        e_long = acc && lng;
        e_set  = acc && bus.i_rdwen && (u == 3 || (u == 1 && !bus.i_lsu_wr));
        if (rst) begin
            foreach (m_sb[k]) m_sb[k] = 1'b0;
            m_cnt = 0;
            m_err = 1'b0;
            m_ok  = 1'b1;
        end else begin
            if (bus.i_lwb_vld) begin
                li = int'(bus.i_lwb_rdidx);
                if (li == 0 || !m_sb[li]) m_err = 1'b1;
                m_sb[li] = 1'b0;
            end
            if (e_set) m_sb[int'(bus.i_rdidx)] = 1'b1;
            m_sb[0] = 1'b0;
            m_cnt = m_cnt + (e_long ? 1 : 0) - (bus.i_lwb_vld ? 1 : 0) - (bus.i_nwb_done ? 1 : 0);
            if (m_cnt < 0) begin
                m_cnt = 0;
                m_err = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.i_dec_vld = 1'b0; bus.i_rdwen = 1'b0; bus.i_rdidx = 5'd0;
        bus.i_rs1ren = 1'b0; bus.i_rs1idx = 5'd0; bus.i_rs2ren = 1'b0; bus.i_rs2idx = 5'd0;
        bus.i_decinfo_grp = 6'd0; bus.i_lsu_wr = 1'b0;
        bus.i_alu_rdy = 1'b1; bus.i_lsu_rdy = 1'b1; bus.i_bju_rdy = 1'b1;
        bus.i_mdu_rdy = 1'b1; bus.i_scu_rdy = 1'b1;
        bus.i_lwb_vld = 1'b0; bus.i_lwb_rdidx = 5'd0; bus.i_nwb_done = 1'b0; bus.i_flush = 1'b0;
    endtask

    // u: 0 alu, 1 lsu, 2 bju, 3 mdu, 4 scu, 5 no-op
    task automatic instr(input int u, input int rd, input int rs1, input bit e1,
                         input int rs2, input bit e2, input bit wr);
        logic [5:0] g;
        g = 6'd0;
        if (u < 5) g[u] = 1'b1;
        bus.i_dec_vld = 1'b1; bus.i_decinfo_grp = g;
        bus.i_rdidx = 5'(rd); bus.i_rdwen = (rd != 0) && !wr;
        bus.i_rs1idx = 5'(rs1); bus.i_rs1ren = e1;
        bus.i_rs2idx = 5'(rs2); bus.i_rs2ren = e2;
        bus.i_lsu_wr = wr;
    endtask

    task automatic lwb(input bit v, input int idx);
        bus.i_lwb_vld = v; bus.i_lwb_rdidx = 5'(idx);
    endtask

    int pend[$];
    int n_acc = 0;

    initial begin
        rst = 1'b1;
        clr_in();
        instr(0, 3, 1, 1'b1, 2, 1'b1, 1'b0);
        #2;
        chk("rst_alu_vld", bus.o_alu_vld, 1'b0);
        chk("rst_dec_rdy", bus.o_dec_rdy, 1'b0);
        cyc(); cyc();
        rst = 1'b0; clr_in();
        #1;
        chk("post_rst_idle", bus.o_idle, 1'b1);
        chk("post_rst_err", bus.o_err, 1'b0);

        // Load-use stall released by same-cycle writeback
        cyc(); instr(1, 5, 0, 1'b0, 0, 1'b0, 1'b0); #1;
        chk("ld5_issue", bus.o_lsu_vld, 1'b1);
        chk("ld5_rdy", bus.o_dec_rdy, 1'b1);
        cyc(); instr(0, 6, 5, 1'b1, 1, 1'b1, 1'b0); #1;
        chk("use5_stall", bus.o_alu_vld, 1'b0);
        chk("ld5_busy_idle", bus.o_idle, 1'b0);
        cyc(); #1;
        chk("use5_stall2", bus.o_alu_vld, 1'b0);
        cyc(); lwb(1'b1, 5); #1;
        chk("use5_bypass", bus.o_alu_vld, 1'b1);
        cyc(); lwb(1'b0, 0); instr(0, 7, 5, 1'b1, 0, 1'b0, 1'b0); #1;
        chk("sb5_cleared", bus.o_alu_vld, 1'b1);

        // Outstanding limit
        for (int i = 1; i <= 4; i++) begin
            cyc(); instr(3, i, 0, 1'b0, 0, 1'b0, 1'b0); #1;
            chk("mdu_fill", bus.o_mdu_vld, 1'b1);
        end
        cyc(); instr(3, 8, 0, 1'b0, 0, 1'b0, 1'b0); #1;
        chk("mdu_full", bus.o_mdu_vld, 1'b0);
        cyc(); lwb(1'b1, 1); #1;
        chk("mdu_full_wb", bus.o_mdu_vld, 1'b0);
        cyc(); lwb(1'b0, 0); #1;
        chk("mdu_fifth", bus.o_mdu_vld, 1'b1);
        cyc(); bus.i_dec_vld = 1'b0; lwb(1'b1, 2);
        cyc(); lwb(1'b1, 3);
        cyc(); lwb(1'b1, 4);
        cyc(); lwb(1'b1, 8);
        cyc(); lwb(1'b0, 0); #1;
        chk("mdu_drained", bus.o_idle, 1'b1);

        // CSR waits for a drained pipeline
        cyc(); instr(1, 10, 0, 1'b0, 0, 1'b0, 1'b0);
        cyc(); instr(1, 0, 1, 1'b1, 2, 1'b1, 1'b1); #1;
        chk("store_issue", bus.o_lsu_vld, 1'b1);
        cyc(); instr(4, 0, 0, 1'b0, 0, 1'b0, 1'b0); #1;
        chk("csr_wait", bus.o_scu_vld, 1'b0);
        cyc(); lwb(1'b1, 10); bus.i_nwb_done = 1'b1; #1;
        chk("csr_wait_cpl", bus.o_scu_vld, 1'b0);
        cyc(); lwb(1'b0, 0); bus.i_nwb_done = 1'b0; #1;
        chk("csr_issue", bus.o_scu_vld, 1'b1);
        chk("csr_idle", bus.o_idle, 1'b1);

        // Flush blocks issue but not writeback
        cyc(); instr(1, 7, 0, 1'b0, 0, 1'b0, 1'b0);
        cyc(); instr(0, 3, 1, 1'b1, 0, 1'b0, 1'b0); bus.i_flush = 1'b1; lwb(1'b1, 7); #1;
        chk("flush_alu_vld", bus.o_alu_vld, 1'b0);
        chk("flush_dec_rdy", bus.o_dec_rdy, 1'b0);
        cyc(); bus.i_flush = 1'b0; lwb(1'b0, 0); instr(0, 3, 7, 1'b1, 0, 1'b0, 1'b0); #1;
        chk("flush_sb7_clr", bus.o_alu_vld, 1'b1);

        // WAW with same-cycle writeback: set wins
        cyc(); instr(1, 9, 0, 1'b0, 0, 1'b0, 1'b0);
        cyc(); lwb(1'b1, 9); #1;
        chk("waw9_issue", bus.o_lsu_vld, 1'b1);
        cyc(); lwb(1'b0, 0); instr(0, 4, 9, 1'b1, 0, 1'b0, 1'b0); #1;
        chk("waw9_busy", bus.o_alu_vld, 1'b0);
        cyc(); lwb(1'b1, 9); #1;
        chk("waw9_release", bus.o_alu_vld, 1'b1);
        cyc(); lwb(1'b0, 0); bus.i_dec_vld = 1'b0; #1;
        chk("waw9_idle", bus.o_idle, 1'b1);

        // Underflow error, then reset clears error and scoreboard
        cyc(); bus.i_nwb_done = 1'b1;
        cyc(); bus.i_nwb_done = 1'b0; #1;
        chk("underflow_err", bus.o_err, 1'b1);
        chk("underflow_idle", bus.o_idle, 1'b1);
        instr(1, 12, 0, 1'b0, 0, 1'b0, 1'b0); #1;
        chk("ld12_issue", bus.o_lsu_vld, 1'b1);
        cyc(); bus.i_dec_vld = 1'b0; rst = 1'b1;
        cyc(); rst = 1'b0; instr(0, 4, 12, 1'b1, 0, 1'b0, 1'b0); #1;
        chk("rst_err_clr", bus.o_err, 1'b0);
        chk("rst_sb_clr", bus.o_alu_vld, 1'b1);
        chk("rst_idle", bus.o_idle, 1'b1);

        // Randomized traffic with a well-behaved completion environment
        pend.delete();
        for (int c = 0; c < 3000; c++) begin
            bit flush_prev;
            int u, st, pick;
            logic [5:0] g;
            cyc();
            if (e_acc) n_acc++;
            if (e_long) pend.push_back(e_set ? int'(bus.i_rdidx) : -1);
            flush_prev = bus.i_flush;
            lwb(1'b0, 0);
            bus.i_nwb_done = 1'b0;
            if (pend.size() > 0 && $urandom_range(0, 1) == 0) begin
                st = $urandom_range(0, pend.size() - 1);
                pick = -1;
                for (int k = 0; k < pend.size(); k++)
                    if (pick < 0 && pend[(st + k) % pend.size()] >= 0) pick = (st + k) % pend.size();
                if (pick >= 0) begin
                    lwb(1'b1, pend[pick]);
                    pend.delete(pick);
                end
            end
            if (pend.size() > 0 && $urandom_range(0, 1) == 0) begin
                pick = -1;
                for (int k = 0; k < pend.size(); k++) if (pick < 0 && pend[k] < 0) pick = k;
                if (pick >= 0) begin
                    bus.i_nwb_done = 1'b1;
                    pend.delete(pick);
                end
            end
            if (!bus.i_dec_vld || e_acc || flush_prev) begin
                u = $urandom_range(0, 5);
                g = 6'd0;
                if (u < 5) g[u] = 1'b1;
                for (int k = u + 1; k < 5; k++) if ($urandom_range(0, 3) == 0) g[k] = 1'b1;
                g[5] = 1'($urandom_range(0, 1));
                bus.i_decinfo_grp = g;
                bus.i_lsu_wr = (u == 1) && ($urandom_range(0, 2) == 0);
                bus.i_rdidx = 5'($urandom_range(0, 7));
                bus.i_rdwen = (bus.i_rdidx != 5'd0) && !bus.i_lsu_wr && ($urandom_range(0, 3) != 0);
                bus.i_rs1idx = 5'($urandom_range(0, 7));
                bus.i_rs1ren = 1'($urandom_range(0, 1));
                bus.i_rs2idx = 5'($urandom_range(0, 7));
                bus.i_rs2ren = 1'($urandom_range(0, 1));
                bus.i_dec_vld = ($urandom_range(0, 3) != 0);
            end
            bus.i_alu_rdy = ($urandom_range(0, 3) != 0);
            bus.i_lsu_rdy = ($urandom_range(0, 3) != 0);
            bus.i_bju_rdy = ($urandom_range(0, 3) != 0);
            bus.i_mdu_rdy = ($urandom_range(0, 3) != 0);
            bus.i_scu_rdy = ($urandom_range(0, 3) != 0);
            bus.i_flush = ($urandom_range(0, 15) == 0);
        end
        cyc();
        chk("random_progress", n_acc > 200, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
